// File: rtl/inst_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction, feeds the external
// decoder, then walks sub-block and main-block micro-steps with the datapath.
module inst_sequencer #(
  parameter int SB_STEPS = 2,  // steps for a nonzero sub-block, 1..8
  parameter int IB_STEPS = 3   // steps for the main block, 1..8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [15:0] instcode,
  output logic        inst_ready,
  output logic [15:0] ir,
  input  logic [4:0]  dec_ib,
  input  logic [4:0]  dec_sb,
  input  logic [2:0]  dec_op,
  output logic        uop_valid,
  output logic [4:0]  uop_blk,
  output logic [2:0]  uop_step,
  input  logic        uop_ack,
  output logic [2:0]  op_out,
  output logic        done,
  output logic        illegal,
  output logic        busy,
  input  logic        abort
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. Instruction side: inst_valid/inst_ready. Micro-step side: uop_valid/uop_ack,
  // where uop_blk/uop_step stay stable until the ack edge.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SUB    = 3'd2,
    S_MAIN   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam logic [2:0] SB_LAST    = 3'(SB_STEPS - 1);
  localparam logic [2:0] IB_LAST    = 3'(IB_STEPS - 1);
  localparam logic [4:0] IB_ILLEGAL = 5'd31;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  ib_q, ib_d;
  logic [4:0]  sb_q, sb_d;
  logic [2:0]  op_q, op_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ir_q    <= '0;
      ib_q    <= '0;
      sb_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      ib_q    <= ib_d;
      sb_q    <= sb_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    ib_d    = ib_q;
    sb_d    = sb_q;
    op_d    = op_q;
    if (abort) begin
      // Flush keeps ir/op_out so the datapath can still inspect the last instruction.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inst_valid) begin
            ir_d    = instcode;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          ib_d  = dec_ib;
          sb_d  = dec_sb;
          op_d  = dec_op;
          cnt_d = '0;
          if (dec_ib == IB_ILLEGAL)  state_d = S_ERR;
          else if (dec_sb != 5'd0)   state_d = S_SUB;
          else                       state_d = S_MAIN;
        end
        S_SUB: begin
          if (uop_ack) begin
            if (cnt_q == SB_LAST) begin
              cnt_d   = '0;
              state_d = S_MAIN;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_MAIN: begin
          if (uop_ack) begin
            if (cnt_q == IB_LAST) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and counter only; an abort suppresses the
  // completion pulses and blocks acceptance in the same cycle.
  always_comb begin
    inst_ready = (state_q == S_IDLE) && !abort;
    busy       = (state_q != S_IDLE);
    uop_valid  = (state_q == S_SUB) || (state_q == S_MAIN);
    uop_blk    = 5'd0;
    if (state_q == S_SUB)  uop_blk = sb_q;
    if (state_q == S_MAIN) uop_blk = ib_q;
    uop_step   = uop_valid ? cnt_q : 3'd0;
    done       = (state_q == S_DONE) && !abort;
    illegal    = (state_q == S_ERR) && !abort;
  end

  assign ir     = ir_q;
  assign op_out = op_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: expected per-cycle traces are generated from the
// instruction-level behaviour, then applied and compared cycle by cycle.
module tb_inst_sequencer;

  localparam int SB_STEPS = 2;
  localparam int IB_STEPS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [15:0] instcode;
  logic        inst_ready;
  logic [15:0] ir;
  logic [4:0]  dec_ib, dec_sb;
  logic [2:0]  dec_op;
  logic        uop_valid;
  logic [4:0]  uop_blk;
  logic [2:0]  uop_step;
  logic        uop_ack;
  logic [2:0]  op_out;
  logic        done, illegal, busy, abort;

  inst_sequencer #(.SB_STEPS(SB_STEPS), .IB_STEPS(IB_STEPS)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .instcode(instcode),
    .inst_ready(inst_ready), .ir(ir), .dec_ib(dec_ib), .dec_sb(dec_sb),
    .dec_op(dec_op), .uop_valid(uop_valid), .uop_blk(uop_blk),
    .uop_step(uop_step), .uop_ack(uop_ack), .op_out(op_out), .done(done),
    .illegal(illegal), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational decoder: {ib, sb, op}.
  function automatic logic [12:0] dec_fn(input logic [15:0] c);
    case (c)
      16'h3000: return {5'd17, 5'd0,  3'd1};
      16'h0410: return {5'd5,  5'd10, 3'd0};
      16'hFFFF: return {5'd31, 5'd7,  3'd6};
      16'h1800: return {5'd19, 5'd0,  3'd2};
      16'h0820: return {5'd1,  5'd11, 3'd0};
      default:  return {c[4:0], {2'b00, c[12:10]}, c[15:13]};
    endcase
  endfunction

  logic [12:0] dec_bus;
  assign dec_bus = dec_fn(ir);
  assign dec_ib  = dec_bus[12:8];
  assign dec_sb  = dec_bus[7:3];
  assign dec_op  = dec_bus[2:0];

  typedef struct {
    logic        rst, valid, ack, abort;
    logic [15:0] code;
    logic        ready, busy, uv, done, ill;
    logic [4:0]  blk;
    logic [2:0]  step;
    logic [2:0]  op;
    logic [15:0] ir;
  } vec_t;

  typedef struct {
    logic [15:0] code;
    int          stall_at;
    int          stall_len;
    logic [4:0]  first_blk;
    logic [4:0]  last_blk;
    logic [2:0]  op;
    int          uv_cycles;
    int          lat;
    bit          is_ill;
  } tc_t;

  vec_t        trace[$];
  logic [15:0] m_ir;
  logic [2:0]  m_op;
  int          n_checks = 0;
  int          n_errors = 0;
  int          obs_done, obs_ill, obs_uv;
  logic [4:0]  obs_first, obs_last;
  logic [2:0]  obs_op;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp, input int idx);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t base(input logic [15:0] ir_e, input logic [2:0] op_e);
    vec_t r;
    r.rst = 1'b0; r.valid = 1'b0; r.ack = 1'b0; r.abort = 1'b0; r.code = 16'h0;
    r.ready = 1'b0; r.busy = 1'b1; r.uv = 1'b0; r.done = 1'b0; r.ill = 1'b0;
    r.blk = 5'd0; r.step = 3'd0; r.op = op_e; r.ir = ir_e;
    return r;
  endfunction

  function automatic logic idle_ack(input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic gen_idle(input bit blocked);
    vec_t r;
    r = base(m_ir, m_op);
    r.busy  = 1'b0;
    r.ready = !blocked;
    r.ack   = 1'($urandom_range(0, 1));
    if (blocked) begin
      r.valid = 1'b1;
      r.abort = 1'b1;
      r.code  = 16'($urandom);
    end
    trace.push_back(r);
  endtask

  // One instruction as seen from outside: accept, one decode cycle, then either a
  // single illegal cycle or every step held until acked, then one done cycle.
  task automatic gen_inst(input logic [15:0] code, input int stall_at, input int stall_len,
                          input bit rnd, input bit may_abort);
    vec_t tq[$];
    vec_t r;
    logic [12:0] d;
    logic [4:0] ib, sb;
    logic [2:0] op;
    int si, k, cut;
    d = dec_fn(code);
    ib = d[12:8]; sb = d[7:3]; op = d[2:0];
    r = base(m_ir, m_op);
    r.valid = 1'b1; r.code = code; r.ready = 1'b1; r.busy = 1'b0; r.ack = idle_ack(rnd);
    tq.push_back(r);
    r = base(code, m_op);
    r.ack = idle_ack(rnd);
    tq.push_back(r);
    if (ib == 5'd31) begin
      r = base(code, op);
      r.ill = 1'b1; r.ack = idle_ack(rnd);
      tq.push_back(r);
    end else begin
      si = 0;
      for (int b = 0; b < 2; b++) begin
        int n;
        n = (b == 0) ? ((sb != 5'd0) ? SB_STEPS : 0) : IB_STEPS;
        for (int s = 0; s < n; s++) begin
          k = rnd ? int'($urandom_range(0, 3)) : ((si == stall_at) ? stall_len : 0);
          r = base(code, op);
          r.uv = 1'b1; r.blk = (b == 0) ? sb : ib; r.step = 3'(s);
          r.ack = 1'b0;
          for (int j = 0; j < k; j++) tq.push_back(r);
          r.ack = 1'b1;
          tq.push_back(r);
          si++;
        end
      end
      r = base(code, op);
      r.done = 1'b1; r.ack = idle_ack(rnd);
      tq.push_back(r);
    end
    cut = -1;
    if (may_abort && $urandom_range(0, 3) == 0) begin
      cut = int'($urandom_range(1, tq.size() - 2));
      tq[cut].abort = 1'b1;
      tq = tq[0:cut];
    end
    m_ir = code;
    if (cut != 1) m_op = op;
    foreach (tq[i]) trace.push_back(tq[i]);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; inst_valid = v.valid; instcode = v.code; uop_ack = v.ack; abort = v.abort;
    #1;
    chk("inst_ready", 16'(inst_ready), 16'(v.ready), idx);
    chk("busy",       16'(busy),       16'(v.busy),  idx);
    chk("uop_valid",  16'(uop_valid),  16'(v.uv),    idx);
    chk("uop_blk",    16'(uop_blk),    16'(v.blk),   idx);
    chk("uop_step",   16'(uop_step),   16'(v.step),  idx);
    chk("done",       16'(done),       16'(v.done),  idx);
    chk("illegal",    16'(illegal),    16'(v.ill),   idx);
    chk("op_out",     16'(op_out),     16'(v.op),    idx);
    chk("ir",         ir,              v.ir,         idx);
    if (uop_valid === 1'b1) begin
      if (obs_uv == 0) obs_first = uop_blk;
      obs_last = uop_blk;
      obs_uv++;
    end
    if (done === 1'b1 && obs_done < 0) obs_done = idx;
    if (illegal === 1'b1 && obs_ill < 0) obs_ill = idx;
    obs_op = op_out;
  endtask

  task automatic reset_obs();
    obs_done = -1; obs_ill = -1; obs_uv = 0;
    obs_first = 5'd0; obs_last = 5'd0; obs_op = 3'd0;
  endtask

  task automatic run_trace();
    foreach (trace[i]) apply(trace[i], i);
    trace.delete();
  endtask

  tc_t tcs[5];

  initial begin
    tcs[0] = '{16'h3000, -1, 0, 5'd17, 5'd17, 3'd1, 3, 5, 1'b0};
    tcs[1] = '{16'h0410, -1, 0, 5'd10, 5'd5,  3'd0, 5, 7, 1'b0};
    tcs[2] = '{16'hFFFF, -1, 0, 5'd0,  5'd0,  3'd6, 0, 2, 1'b1};
    tcs[3] = '{16'h1800,  1, 4, 5'd19, 5'd19, 3'd2, 7, 9, 1'b0};
    tcs[4] = '{16'h0820, -1, 0, 5'd11, 5'd1,  3'd0, 5, 7, 1'b0};

    rst = 1'b1; inst_valid = 1'b0; instcode = 16'h0; uop_ack = 1'b0; abort = 1'b0;
    m_ir = 16'h0; m_op = 3'd0;
    repeat (3) @(posedge clk);

    reset_obs();
    gen_idle(1'b0);
    run_trace();

    foreach (tcs[t]) begin
      reset_obs();
      gen_inst(tcs[t].code, tcs[t].stall_at, tcs[t].stall_len, 1'b0, 1'b0);
      gen_idle(1'b0);
      run_trace();
      chk_int("done_latency",    obs_done, tcs[t].is_ill ? -1 : tcs[t].lat);
      chk_int("illegal_latency", obs_ill,  tcs[t].is_ill ? tcs[t].lat : -1);
      chk_int("uop_valid_cycles", obs_uv,  tcs[t].uv_cycles);
      chk_int("first_blk", int'(obs_first), int'(tcs[t].first_blk));
      chk_int("last_blk",  int'(obs_last),  int'(tcs[t].last_blk));
      chk_int("final_op",  int'(obs_op),    int'(tcs[t].op));
    end

    // Abort during SUB step 1, then a normal instruction.
    reset_obs();
    gen_inst(16'h0820, -1, 0, 1'b0, 1'b0);
    trace = trace[0:3];
    trace[3].abort = 1'b1;
    gen_idle(1'b0);
    gen_idle(1'b1);
    run_trace();
    chk_int("abort_no_done",    obs_done, -1);
    chk_int("abort_no_illegal", obs_ill,  -1);
    reset_obs();
    gen_inst(16'h3000, -1, 0, 1'b0, 1'b0);
    gen_idle(1'b0);
    run_trace();
    chk_int("after_abort_latency", obs_done, 5);

    // Reset (with abort) in MAIN step 1, stale ack on the following cycle.
    reset_obs();
    gen_inst(16'h3000, -1, 0, 1'b0, 1'b0);
    trace = trace[0:3];
    trace[3].rst   = 1'b1;
    trace[3].abort = 1'b1;
    m_ir = 16'h0; m_op = 3'd0;
    gen_idle(1'b0);
    trace[trace.size() - 1].ack = 1'b1;
    gen_idle(1'b0);
    run_trace();
    chk_int("reset_no_done", obs_done, -1);
    reset_obs();
    gen_inst(16'h0410, -1, 0, 1'b0, 1'b0);
    gen_idle(1'b0);
    run_trace();
    chk_int("after_reset_latency", obs_done, 7);

    // Random instructions, stalls, idle gaps and aborts.
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) gen_idle(1'($urandom_range(0, 1)));
      gen_inst(16'($urandom_range(0, 65535)), -1, 0, 1'b1, 1'b1);
      run_trace();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
